// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port DataMemory between the CPU load/store path and a debug/loader port.
// Define DMEM_ARB_LOCK_EN to add the dbg_lock input for uninterrupted debug bursts.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_stall,
  output logic                 cpu_rvalid,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [WORD_SIZE-1:0] dbg_addr,
  input  logic [WORD_SIZE-1:0] dbg_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                 dbg_lock,
`endif
  output logic                 dbg_gnt,
  output logic                 dbg_rvalid,
  output logic [WORD_SIZE-1:0] dbg_rdata,
  output logic                 mem_write_en,
  output logic                 mem_read_en,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_write_data,
  input  logic [WORD_SIZE-1:0] mem_read_data
);

  localparam int WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  logic [WaitW-1:0]     dbg_wait_q, dbg_wait_d;
  logic                 cpu_rd_q, dbg_rd_q;
  logic [WORD_SIZE-1:0] cpu_rdata_q, dbg_rdata_q;
  logic                 lock_active;
  logic                 dbg_win, cpu_win;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q;

  // Lock follows dbg_lock at each debug grant and falls as soon as the debug port goes idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else if (!dbg_req) begin
      lock_q <= 1'b0;
    end else if (dbg_win) begin
      lock_q <= dbg_lock;
    end
  end

  assign lock_active = lock_q;
`else
  assign lock_active = 1'b0;
`endif

  // Both grants are forced low while reset is high so no access leaks out mid-reset.
  assign dbg_win = ~reset & dbg_req & (~cpu_req | (dbg_wait_q == WaitMax) | lock_active);
  assign cpu_win = ~reset & cpu_req & ~dbg_win;

  assign dbg_gnt   = dbg_win;
  assign cpu_gnt   = cpu_win;
  assign cpu_stall = cpu_req & ~cpu_win;

  assign mem_write_en   = (dbg_win & dbg_we) | (cpu_win & cpu_we);
  assign mem_read_en    = (dbg_win & ~dbg_we) | (cpu_win & ~cpu_we);
  assign mem_addr       = dbg_win ? dbg_addr  : (cpu_win ? cpu_addr  : '0);
  assign mem_write_data = dbg_win ? dbg_wdata : (cpu_win ? cpu_wdata : '0);

  always_comb begin
    dbg_wait_d = '0;
    if (dbg_req && !dbg_win) begin
      dbg_wait_d = (dbg_wait_q == WaitMax) ? dbg_wait_q : dbg_wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_wait_q <= '0;
      cpu_rd_q   <= 1'b0;
      dbg_rd_q   <= 1'b0;
    end else begin
      dbg_wait_q <= dbg_wait_d;
      cpu_rd_q   <= cpu_win & ~cpu_we;
      dbg_rd_q   <= dbg_win & ~dbg_we;
    end
  end

  // Memory data is passed straight through in the response cycle and captured so it holds afterwards.
  assign cpu_rvalid = cpu_rd_q;
  assign dbg_rvalid = dbg_rd_q;
  assign cpu_rdata  = cpu_rd_q ? mem_read_data : cpu_rdata_q;
  assign dbg_rdata  = dbg_rd_q ? mem_read_data : dbg_rdata_q;

  always_ff @(posedge clk) begin
    cpu_rdata_q <= cpu_rdata;
    dbg_rdata_q <= dbg_rdata;
  end

endmodule
